// File: rtl/ula_arbiter.sv
// rtl/ula_arbiter.sv - round-robin arbiter sharing one ULA between two requesters
// Optional grant counters when ULA_ARB_STATS_EN is defined.
module ula_arbiter #(
  parameter int SLOW_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [4:0]  req0_op,
  input  logic [31:0] req0_data1,
  input  logic [31:0] req0_data2,
  input  logic [4:0]  req0_shamt,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_op,
  input  logic [31:0] req1_data1,
  input  logic [31:0] req1_data2,
  input  logic [4:0]  req1_shamt,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  output logic [4:0]  ula_op,
  output logic [31:0] ula_data1,
  output logic [31:0] ula_data2,
  output logic [4:0]  ula_shamt,
  input  logic [31:0] ula_result,
  input  logic        ula_zero
`ifdef ULA_ARB_STATS_EN
  ,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1
`endif
);

  localparam int CW = (SLOW_LAT > 1) ? $clog2(SLOW_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic          port_q, port_d;
  logic [4:0]    op_q, op_d;
  logic [31:0]   data1_q, data1_d;
  logic [31:0]   data2_q, data2_d;
  logic [4:0]    shamt_q, shamt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsp0_valid_q, rsp0_valid_d;
  logic          rsp1_valid_q, rsp1_valid_d;
  logic [31:0]   rsp0_result_q, rsp0_result_d;
  logic [31:0]   rsp1_result_q, rsp1_result_d;
  logic          rsp0_zero_q, rsp0_zero_d;
  logic          rsp1_zero_q, rsp1_zero_d;
  logic          gnt0, gnt1, exec_drv;
  logic [4:0]    sel_op;

`ifdef ULA_ARB_STATS_EN
  logic [15:0]   grant_cnt0_q, grant_cnt0_d;
  logic [15:0]   grant_cnt1_q, grant_cnt1_d;
  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

  // Ties go to prio; a lone requester always wins.
  assign gnt0 = req0_valid && (!req1_valid || !prio_q);
  assign gnt1 = req1_valid && (!req0_valid || prio_q);
  assign req0_ready = (state_q == IDLE) && !reset && gnt0;
  assign req1_ready = (state_q == IDLE) && !reset && gnt1;
  assign sel_op = req1_ready ? req1_op : req0_op;

  assign exec_drv  = (state_q == EXEC) && !reset;
  assign ula_op    = exec_drv ? op_q    : 5'd0;
  assign ula_data1 = exec_drv ? data1_q : 32'd0;
  assign ula_data2 = exec_drv ? data2_q : 32'd0;
  assign ula_shamt = exec_drv ? shamt_q : 5'd0;

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp0_zero   = rsp0_zero_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp1_zero   = rsp1_zero_q;

  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    port_d        = port_q;
    op_d          = op_q;
    data1_d       = data1_q;
    data2_d       = data2_q;
    shamt_d       = shamt_q;
    cnt_d         = cnt_q;
    rsp0_valid_d  = 1'b0;
    rsp1_valid_d  = 1'b0;
    rsp0_result_d = rsp0_result_q;
    rsp1_result_d = rsp1_result_q;
    rsp0_zero_d   = rsp0_zero_q;
    rsp1_zero_d   = rsp1_zero_q;
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          port_d  = req1_ready;
          op_d    = sel_op;
          data1_d = req1_ready ? req1_data1 : req0_data1;
          data2_d = req1_ready ? req1_data2 : req0_data2;
          shamt_d = req1_ready ? req1_shamt : req0_shamt;
          // Mult and div hold the ULA inputs for SLOW_LAT cycles in total.
          cnt_d   = (sel_op == 5'b00011 || sel_op == 5'b00101) ? CW'(SLOW_LAT - 1) : '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (port_q) begin
            rsp1_valid_d  = 1'b1;
            rsp1_result_d = ula_result;
            rsp1_zero_d   = ula_zero;
          end else begin
            rsp0_valid_d  = 1'b1;
            rsp0_result_d = ula_result;
            rsp0_zero_d   = ula_zero;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        prio_d  = ~port_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ULA_ARB_STATS_EN
  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (req0_ready && grant_cnt0_q != 16'hFFFF) grant_cnt0_d = grant_cnt0_q + 16'd1;
    if (req1_ready && grant_cnt1_q != 16'hFFFF) grant_cnt1_d = grant_cnt1_q + 16'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      prio_q        <= 1'b0;
      port_q        <= 1'b0;
      op_q          <= 5'd0;
      data1_q       <= 32'd0;
      data2_q       <= 32'd0;
      shamt_q       <= 5'd0;
      cnt_q         <= '0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_result_q <= 32'd0;
      rsp1_result_q <= 32'd0;
      rsp0_zero_q   <= 1'b0;
      rsp1_zero_q   <= 1'b0;
`ifdef ULA_ARB_STATS_EN
      grant_cnt0_q  <= 16'd0;
      grant_cnt1_q  <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      port_q        <= port_d;
      op_q          <= op_d;
      data1_q       <= data1_d;
      data2_q       <= data2_d;
      shamt_q       <= shamt_d;
      cnt_q         <= cnt_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp1_result_q <= rsp1_result_d;
      rsp0_zero_q   <= rsp0_zero_d;
      rsp1_zero_q   <= rsp1_zero_d;
`ifdef ULA_ARB_STATS_EN
      grant_cnt0_q  <= grant_cnt0_d;
      grant_cnt1_q  <= grant_cnt1_d;
`endif
    end
  end

endmodule

// File: tb/tb_ula_arbiter.sv
// tb/tb_ula_arbiter.sv - directed self-checking bench for ula_arbiter with a behavioural ULA
module tb_ula_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]  req0_op = 5'd0, req1_op = 5'd0;
  logic [31:0] req0_data1 = 32'd0, req0_data2 = 32'd0;
  logic [31:0] req1_data1 = 32'd0, req1_data2 = 32'd0;
  logic [4:0]  req0_shamt = 5'd0, req1_shamt = 5'd0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
  logic [31:0] rsp0_result, rsp1_result;
  logic [4:0]  ula_op, ula_shamt;
  logic [31:0] ula_data1, ula_data2, ula_result;
  logic        ula_zero;
`ifdef ULA_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] res;

  always #5 clk = ~clk;

  ula_arbiter #(.SLOW_LAT(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_data1(req0_data1),
    .req0_data2(req0_data2), .req0_shamt(req0_shamt), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_data1(req1_data1),
    .req1_data2(req1_data2), .req1_shamt(req1_shamt), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .ula_op(ula_op), .ula_data1(ula_data1), .ula_data2(ula_data2),
    .ula_shamt(ula_shamt), .ula_result(ula_result), .ula_zero(ula_zero)
`ifdef ULA_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // Behavioural ULA: add, sub, or, mult, and, div (divisor 0 forced to 1), sll; others give 0.
  always_comb begin
    case (ula_op)
      5'b00000: ula_result = ula_data1 + ula_data2;
      5'b00001: ula_result = ula_data1 - ula_data2;
      5'b00010: ula_result = ula_data1 | ula_data2;
      5'b00011: ula_result = ula_data1 * ula_data2;
      5'b00100: ula_result = ula_data1 & ula_data2;
      5'b00101: ula_result = ula_data1 / ((ula_data2 == 32'd0) ? 32'd1 : ula_data2);
      5'b00110: ula_result = ula_data1 << ula_shamt;
      default:  ula_result = 32'd0;
    endcase
    ula_zero = (ula_result == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit port, input bit v, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (port) begin
      req1_valid = v; req1_op = op; req1_data1 = a; req1_data2 = b;
    end else begin
      req0_valid = v; req0_op = op; req0_data1 = a; req0_data2 = b;
    end
  endtask

  task automatic run_op(input bit port, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] r);
    int n;
    set_req(port, 1'b1, op, a, b);
    #1;
    n = 0;
    while (!(port ? req1_ready : req0_ready) && n < 10) begin
      tick();
      n++;
    end
    check("run_op_ready_timeout", 32'(n < 10), 32'd1);
    tick();
    set_req(port, 1'b0, 5'd0, 32'd0, 32'd0);
    n = 0;
    while (!(port ? rsp1_valid : rsp0_valid) && n < 10) begin
      tick();
      n++;
    end
    check("run_op_rsp_timeout", 32'(n < 10), 32'd1);
    r = port ? rsp1_result : rsp0_result;
    tick();
  endtask

  initial begin
    // 1: reset, no valid
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_ula_op", 32'(ula_op), 32'd0);
    check("rst_ula_data1", ula_data1, 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_result", rsp1_result, 32'd0);
    check("rst_state", 32'(dut.state_q), 32'd0);

    // 2: fast add on port 0, rsp at T+2
    set_req(0, 1'b1, 5'b00000, 32'd5, 32'd7);
    #1;
    check("add_ready0_T", 32'(req0_ready), 32'd1);
    tick();
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0);
    check("add_rsp0_T1", 32'(rsp0_valid), 32'd0);
    check("add_ula_data1_T1", ula_data1, 32'd5);
    tick();
    check("add_rsp0_T2", 32'(rsp0_valid), 32'd1);
    check("add_result", rsp0_result, 32'd12);
    check("add_zero", 32'(rsp0_zero), 32'd0);
    check("add_rsp1_quiet", 32'(rsp1_valid), 32'd0);
    tick();
    check("add_rsp0_T3", 32'(rsp0_valid), 32'd0);
    check("add_result_hold", rsp0_result, 32'd12);

    // 3: both valid out of reset, round-robin
    reset = 1'b1;
    set_req(0, 1'b1, 5'b00001, 32'd3, 32'd3);
    set_req(1, 1'b1, 5'b00010, 32'hF0, 32'h0F);
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rr_ready0_first", 32'(req0_ready), 32'd1);
    check("rr_ready1_first", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    #1;
    check("rr_ready1_exec", 32'(req1_ready), 32'd0);
    tick();
    check("rr_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("rr_rsp0_result", rsp0_result, 32'd0);
    check("rr_rsp0_zero", 32'(rsp0_zero), 32'd1);
    req0_valid = 1'b1;
    tick();
    check("rr_ready1_second", 32'(req1_ready), 32'd1);
    check("rr_ready0_second", 32'(req0_ready), 32'd0);
    tick(); tick();
    check("rr_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check("rr_rsp1_result", rsp1_result, 32'hFF);
    check("rr_rsp0_quiet", 32'(rsp0_valid), 32'd0);
    tick();
    check("rr_ready0_third", 32'(req0_ready), 32'd1);
    check("rr_ready1_third", 32'(req1_ready), 32'd0);
    tick();
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 5'd0, 32'd0, 32'd0);
    tick(); tick();

    // 4: slow div on port 1 with divisor 0
    set_req(1, 1'b1, 5'b00101, 32'd100, 32'd0);
    #1;
    check("div_ready1_T", 32'(req1_ready), 32'd1);
    tick();
    set_req(1, 1'b0, 5'd0, 32'd0, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("div_ula_op_T%0d", i), 32'(ula_op), 32'b00101);
      check($sformatf("div_ula_data1_T%0d", i), ula_data1, 32'd100);
      check($sformatf("div_rsp1_quiet_T%0d", i), 32'(rsp1_valid), 32'd0);
      tick();
    end
    check("div_rsp1_valid_T5", 32'(rsp1_valid), 32'd1);
    check("div_result", rsp1_result, 32'd100);
    check("div_ula_op_released", 32'(ula_op), 32'd0);
    tick();

    // 5: reset during a slow mult drops it
    set_req(0, 1'b1, 5'b00011, 32'd3, 32'd4);
    tick();
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_ula_op", 32'(ula_op), 32'd0);
    check("mrst_rsp0_result", rsp0_result, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("mrst_no_rsp0_%0d", i), 32'(rsp0_valid), 32'd0);
      tick();
    end
    run_op(0, 5'b00000, 32'd10, 32'd20, res);
    check("mrst_next_add", res, 32'd30);

    // Undefined opcode behaves as fast op; ULA returns 0
    run_op(0, 5'b11111, 32'd9, 32'd9, res);
    check("undef_result", res, 32'd0);
    check("undef_zero", 32'(rsp0_zero), 32'd1);

`ifdef ULA_ARB_STATS_EN
    // 6: grant counters and saturation
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("stats_rst0", 32'(grant_cnt0), 32'd0);
    for (int i = 0; i < 3; i++) run_op(0, 5'b00000, 32'(i), 32'd1, res);
    run_op(1, 5'b00000, 32'd1, 32'd1, res);
    check("stats_cnt0", 32'(grant_cnt0), 32'd3);
    check("stats_cnt1", 32'(grant_cnt1), 32'd1);
    force dut.grant_cnt0_q = 16'hFFFF;
    #1;
    release dut.grant_cnt0_q;
    run_op(0, 5'b00000, 32'd1, 32'd1, res);
    check("stats_sat0", 32'(grant_cnt0), 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
